// File: rtl/sram_arb_pkg.sv
// Shared definitions for sram_arbiter: one-hot FSM encoding, timeout default
// and the data word returned on an aborted read.
package sram_arb_pkg;

  localparam int DW = 16;
  localparam int AW = 16;

  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_ISSUE = 4'b0010;
  localparam logic [3:0] ST_WAIT  = 4'b0100;
  localparam logic [3:0] ST_RESP  = 4'b1000;

  typedef enum logic [3:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    WAIT  = ST_WAIT,
    RESP  = ST_RESP
  } state_t;

  localparam int          TIMEOUT_CYCLES_DEF = 64;
  localparam logic [15:0] ABORT_DATA         = 16'hDEAD;

endpackage

// File: rtl/sram_arb_rr.sv
// Combinational 2-way round-robin picker: a lone requester wins, and on
// contention the port that was not granted last time wins.
module sram_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/sram_arbiter.sv
// Two-port req/ack arbiter in front of sram_controller, one access at a time.
// Define SRAM_ARB_TIMEOUT_EN to bound WAIT and abort with pN_err / 16'hDEAD.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  input  logic          mem_busy,
  output logic          timeout_flag
);

  if (TIMEOUT_CYCLES < 8 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("sram_arbiter: TIMEOUT_CYCLES must be in 8..255");
  end

  state_t               r_state;
  logic                 r_last_grant;
  logic                 r_gid;
  logic                 r_we;
  logic [AW-1:0]        r_addr;
  logic [DW-1:0]        r_wdata;
  logic                 r_wr;
  logic                 r_rd;
  logic [1:0]           r_ack;
  logic [1:0][DW-1:0]   r_rdata;

  logic                 w_gnt_valid;
  logic                 w_gnt_id;
  logic                 w_we;
  logic [AW-1:0]        w_addr;
  logic [DW-1:0]        w_wdata;

  sram_arb_rr u_rr (
    .req        ({p1_req, p0_req}),
    .last_grant (r_last_grant),
    .gnt_valid  (w_gnt_valid),
    .gnt_id     (w_gnt_id)
  );

  assign w_we    = w_gnt_id ? p1_we    : p0_we;
  assign w_addr  = w_gnt_id ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt_id ? p1_wdata : p0_wdata;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic [1:0] r_err;
  logic       r_tflag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_gid        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_ack        <= '0;
      r_rdata      <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_err        <= '0;
      r_tflag      <= 1'b0;
`endif
    end else begin
      // strobes and acks are single-cycle pulses by default
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_ack <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      r_err <= '0;
`endif
      case (r_state)
        IDLE: begin
          if (!mem_busy && w_gnt_valid) begin
            r_gid        <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_wr         <= w_we;
            r_rd         <= ~w_we;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
`ifdef SRAM_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT: begin
          if (mem_valid) begin
            if (!r_we) r_rdata[r_gid] <= mem_rdata;
            r_ack[r_gid] <= 1'b1;
            r_state      <= RESP;
          end
`ifdef SRAM_ARB_TIMEOUT_EN
          else if (r_cnt == 8'(TIMEOUT_CYCLES)) begin
            if (!r_we) r_rdata[r_gid] <= ABORT_DATA;
            r_ack[r_gid] <= 1'b1;
            r_err[r_gid] <= 1'b1;
            r_tflag      <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wr    = r_wr;
  assign mem_rd    = r_rd;
  assign p0_ack    = r_ack[0];
  assign p1_ack    = r_ack[1];
  assign p0_rdata  = r_rdata[0];
  assign p1_rdata  = r_rdata[1];

`ifdef SRAM_ARB_TIMEOUT_EN
  assign p0_err       = r_err[0];
  assign p1_err       = r_err[1];
  assign timeout_flag = r_tflag;
`else
  assign p0_err       = 1'b0;
  assign p1_err       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule
